// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM pipeline stage (master)
// and the data memory (slave).
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one data-memory access per instruction, stalls
// upstream until the memory acknowledges, and produces the MEM/WB register.
module mem_access_unit (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic              in_wb_sel,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_pc,
    input  logic [32:0]       in_alu,
    input  logic [31:0]       in_dat2,
    input  logic [4:0]        in_rd,
    output logic              stall,
    mem_access_unit_if.master dmem,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              mem_exc,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state, state_next;
    logic [31:0] addr;
    logic        unused_alu_msb;
    logic        is_mem, funct3_ok, misaligned, fault, accept;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [15:0] lane;
    logic [31:0] load_data;

    logic        req_q, we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        reg_write_q;

    assign addr           = in_alu[31:0];
    assign unused_alu_msb = in_alu[32];

    // Unsigned load sizes are only legal for reads; read+write together is a fault.
    always_comb begin
        is_mem = in_mem_read | in_mem_write;
        case (in_funct3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = in_mem_read;
            default:                funct3_ok = 1'b0;
        endcase
        misaligned = ((in_funct3[1:0] == 2'b01) && addr[0]) ||
                     ((in_funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        fault  = (in_mem_read & in_mem_write) | ~funct3_ok | misaligned;
        accept = in_valid & is_mem & ~fault;
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = in_dat2;
        if (in_mem_write) begin
            case (in_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << addr[1:0];
                    st_wdata = {4{in_dat2[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << addr[1:0];
                    st_wdata = {2{in_dat2[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Halfwords are aligned, so the same byte-offset shift selects either lane.
    always_comb begin
        lane = 16'(dmem.dmem_rdata >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'h000000, lane[7:0]};
            3'b101:  load_data = {16'h0000, lane[15:0]};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (dmem.dmem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = accept;
            BUSY:    stall = ~dmem.dmem_ack;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            mem_exc      <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'h0;
        end else if (state == IDLE) begin
            if (!in_valid) begin
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
                mem_exc      <= 1'b0;
            end else if (!is_mem) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= in_reg_write;
                mem_exc      <= 1'b0;
                wb_rd        <= in_rd;
                wb_data      <= in_wb_sel ? (in_pc + 32'd4) : addr;
            end else if (fault) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= 1'b0;
                mem_exc      <= 1'b1;
                wb_rd        <= in_rd;
                wb_data      <= addr;
            end else begin
                req_q        <= 1'b1;
                we_q         <= in_mem_write;
                be_q         <= st_be;
                addr_q       <= {addr[31:2], 2'b00};
                wdata_q      <= st_wdata;
                funct3_q     <= in_funct3;
                off_q        <= addr[1:0];
                rd_q         <= in_rd;
                reg_write_q  <= in_reg_write;
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
                mem_exc      <= 1'b0;
            end
        end else if (dmem.dmem_ack) begin
            req_q        <= 1'b0;
            wb_valid     <= 1'b1;
            mem_exc      <= 1'b0;
            wb_rd        <= rd_q;
            wb_reg_write <= we_q ? 1'b0 : reg_write_q;
            wb_data      <= we_q ? 32'h0 : load_data;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table for single-cycle ALU and
// fault cases, plus hand-written sequences for multi-cycle memory accesses.
module tb_mem_access_unit;
    logic        clk;
    logic        rst;
    logic        in_valid, in_mem_read, in_mem_write, in_reg_write, in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_pc;
    logic [32:0] in_alu;
    logic [31:0] in_dat2;
    logic [4:0]  in_rd;
    logic        stall;
    logic        wb_valid, wb_reg_write, mem_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if dmem_bus ();

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_reg_write (in_reg_write),
        .in_wb_sel    (in_wb_sel),
        .in_funct3    (in_funct3),
        .in_pc        (in_pc),
        .in_alu       (in_alu),
        .in_dat2      (in_dat2),
        .in_rd        (in_rd),
        .stall        (stall),
        .dmem         (dmem_bus),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .mem_exc      (mem_exc),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {valid, mem_read, mem_write, reg_write, wb_sel}; expct = {wb_valid, wb_reg_write, mem_exc, check rd/data}
    typedef struct {
        logic [4:0]  ctl;
        logic [2:0]  funct3;
        logic [31:0] pc;
        logic [32:0] alu;
        logic [31:0] dat2;
        logic [4:0]  rd;
        logic        ack;
        logic [3:0]  expct;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] ctl, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [32:0] alu,
                                input logic [31:0] dat2, input logic [4:0] rd,
                                input logic ack, input logic [3:0] expct,
                                input logic [4:0] exp_rd, input logic [31:0] exp_data);
        vec_t v;
        v.ctl = ctl; v.funct3 = f3; v.pc = pc; v.alu = alu; v.dat2 = dat2;
        v.rd = rd; v.ack = ack; v.expct = expct; v.exp_rd = exp_rd; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        {in_valid, in_mem_read, in_mem_write, in_reg_write, in_wb_sel} = v.ctl;
        in_funct3 = v.funct3;
        in_pc     = v.pc;
        in_alu    = v.alu;
        in_dat2   = v.dat2;
        in_rd     = v.rd;
        dmem_bus.dmem_ack = v.ack;
    endtask

    task automatic set_idle();
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_reg_write = 1'b0; in_wb_sel = 1'b0; in_funct3 = 3'b000;
        in_pc = 32'h0; in_alu = 33'h0; in_dat2 = 32'h0; in_rd = 5'd0;
        dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'h0;
    endtask

    task automatic run_vector(input string name, input vec_t v);
        @(negedge clk);
        apply_stimulus(v);
        #1;
        check_output({name, " stall"}, stall, 32'd0);
        @(posedge clk);
        #1;
        check_output({name, " wb_valid"}, wb_valid, v.expct[3]);
        check_output({name, " wb_reg_write"}, wb_reg_write, v.expct[2]);
        check_output({name, " mem_exc"}, mem_exc, v.expct[1]);
        check_output({name, " dmem_req"}, dmem_bus.dmem_req, 32'd0);
        if (v.expct[0]) begin
            check_output({name, " wb_rd"}, wb_rd, v.exp_rd);
            check_output({name, " wb_data"}, wb_data, v.exp_data);
        end
    endtask

    // One legal access: accept, hold for wait_cycles without ack, then complete.
    task automatic run_access(input string name, input logic mr, input logic mw,
                              input logic rw, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] dat2,
                              input logic [4:0] rd, input int wait_cycles,
                              input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic exp_rw, input logic [31:0] exp_data);
        @(negedge clk);
        in_valid = 1'b1; in_mem_read = mr; in_mem_write = mw; in_reg_write = rw;
        in_wb_sel = 1'b0; in_funct3 = f3; in_pc = 32'h0000_0400;
        in_alu = {1'b0, addr}; in_dat2 = dat2; in_rd = rd;
        dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'h0;
        #1;
        check_output({name, " accept stall"}, stall, 32'd1);
        check_output({name, " accept req"}, dmem_bus.dmem_req, 32'd0);
        for (int c = 0; c <= wait_cycles; c++) begin
            @(negedge clk);
            if (c == wait_cycles) begin
                dmem_bus.dmem_ack   = 1'b1;
                dmem_bus.dmem_rdata = rdata;
            end
            #1;
            check_output($sformatf("%s c%0d stall", name, c), stall, (c == wait_cycles) ? 32'd0 : 32'd1);
            check_output($sformatf("%s c%0d req", name, c), dmem_bus.dmem_req, 32'd1);
            check_output($sformatf("%s c%0d we", name, c), dmem_bus.dmem_we, mw);
            check_output($sformatf("%s c%0d be", name, c), dmem_bus.dmem_be, exp_be);
            check_output($sformatf("%s c%0d addr", name, c), dmem_bus.dmem_addr, exp_addr);
            if (mw) check_output($sformatf("%s c%0d wdata", name, c), dmem_bus.dmem_wdata, exp_wdata);
            check_output($sformatf("%s c%0d wb_valid", name, c), wb_valid, 32'd0);
        end
        @(posedge clk);
        #1;
        check_output({name, " done req"}, dmem_bus.dmem_req, 32'd0);
        check_output({name, " done wb_valid"}, wb_valid, 32'd1);
        check_output({name, " done mem_exc"}, mem_exc, 32'd0);
        check_output({name, " done wb_rd"}, wb_rd, rd);
        check_output({name, " done wb_reg_write"}, wb_reg_write, exp_rw);
        check_output({name, " done wb_data"}, wb_data, exp_data);
        @(negedge clk);
        set_idle();
    endtask

    vec_t vectors[13];

    initial begin
        vectors[0]  = mk(5'b10010, 3'b000, 32'h0000_1000, 33'h0_0000_1234, 32'h0, 5'd5,  1'b0, 4'b1101, 5'd5,  32'h0000_1234);
        vectors[1]  = mk(5'b10011, 3'b000, 32'hFFFF_FFFC, 33'h0_0000_0040, 32'h0, 5'd1,  1'b0, 4'b1101, 5'd1,  32'h0000_0000);
        vectors[2]  = mk(5'b10000, 3'b000, 32'h0000_0000, 33'h1_DEAD_BEEF, 32'h0, 5'd31, 1'b1, 4'b1001, 5'd31, 32'hDEAD_BEEF);
        vectors[3]  = mk(5'b00010, 3'b000, 32'h0000_0000, 33'h0_0000_0777, 32'h0, 5'd3,  1'b1, 4'b0000, 5'd0,  32'h0);
        vectors[4]  = mk(5'b11010, 3'b010, 32'h0000_0000, 33'h0_0000_0001, 32'h0, 5'd9,  1'b0, 4'b1011, 5'd9,  32'h0000_0001);
        vectors[5]  = mk(5'b10010, 3'b000, 32'h0000_0000, 33'h0_0000_0055, 32'h0, 5'd0,  1'b0, 4'b1101, 5'd0,  32'h0000_0055);
        vectors[6]  = mk(5'b11010, 3'b001, 32'h0000_0000, 33'h0_0000_0003, 32'h0, 5'd10, 1'b0, 4'b1011, 5'd10, 32'h0000_0003);
        vectors[7]  = mk(5'b11010, 3'b011, 32'h0000_0000, 33'h0_0000_0000, 32'h0, 5'd11, 1'b0, 4'b1011, 5'd11, 32'h0000_0000);
        vectors[8]  = mk(5'b10100, 3'b100, 32'h0000_0000, 33'h0_0000_0010, 32'h1, 5'd12, 1'b0, 4'b1011, 5'd12, 32'h0000_0010);
        vectors[9]  = mk(5'b11110, 3'b010, 32'h0000_0000, 33'h0_0000_0020, 32'h0, 5'd13, 1'b0, 4'b1011, 5'd13, 32'h0000_0020);
        vectors[10] = mk(5'b11010, 3'b101, 32'h0000_0000, 33'h0_0000_0005, 32'h0, 5'd14, 1'b0, 4'b1011, 5'd14, 32'h0000_0005);
        vectors[11] = mk(5'b10100, 3'b010, 32'h0000_0000, 33'h0_0000_0006, 32'h0, 5'd15, 1'b0, 4'b1011, 5'd15, 32'h0000_0006);
        vectors[12] = mk(5'b00000, 3'b000, 32'h0000_0000, 33'h0_0000_0000, 32'h0, 5'd0,  1'b0, 4'b0000, 5'd0,  32'h0);

        set_idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_output("reset stall", stall, 32'd0);
        check_output("reset dmem_req", dmem_bus.dmem_req, 32'd0);
        check_output("reset dmem_we", dmem_bus.dmem_we, 32'd0);
        check_output("reset dmem_be", dmem_bus.dmem_be, 32'd0);
        check_output("reset dmem_addr", dmem_bus.dmem_addr, 32'd0);
        check_output("reset dmem_wdata", dmem_bus.dmem_wdata, 32'd0);
        check_output("reset wb_valid", wb_valid, 32'd0);
        check_output("reset wb_reg_write", wb_reg_write, 32'd0);
        check_output("reset mem_exc", mem_exc, 32'd0);
        check_output("reset wb_rd", wb_rd, 32'd0);
        check_output("reset wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) run_vector($sformatf("vec%0d", i), vectors[i]);

        run_access("LB103",  1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd4, 1,
                   32'h80FF_0000, 32'h0000_0100, 4'b1111, 32'h0, 1'b1, 32'hFFFF_FF80);
        run_access("SH202",  1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd6, 0,
                   32'h0, 32'h0000_0200, 4'b1100, 32'h1234_1234, 1'b0, 32'h0);
        run_access("LHU002", 1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0002, 32'h0, 5'd7, 5,
                   32'h8001_0000, 32'h0000_0000, 4'b1111, 32'h0, 1'b1, 32'h0000_8001);
        run_access("SB101",  1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0000_00AB, 5'd2, 0,
                   32'h0, 32'h0000_0100, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'h0);
        run_access("LHFFE",  1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0FFE, 32'h0, 5'd20, 2,
                   32'h8001_1234, 32'h0000_0FFC, 4'b1111, 32'h0, 1'b1, 32'hFFFF_8001);
        run_access("LW040",  1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd8, 0,
                   32'hCAFE_F00D, 32'h0000_0040, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D);
        run_access("LBU102", 1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0102, 32'h0, 5'd21, 1,
                   32'h00A5_0000, 32'h0000_0100, 4'b1111, 32'h0, 1'b1, 32'h0000_00A5);
        run_access("SW01C",  1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_001C, 32'h1122_3344, 5'd22, 0,
                   32'h0, 32'h0000_001C, 4'b1111, 32'h1122_3344, 1'b0, 32'h0);

        // Reset in the middle of a pending access, then a stale ack.
        @(negedge clk);
        in_valid = 1'b1; in_mem_read = 1'b1; in_reg_write = 1'b1;
        in_funct3 = 3'b010; in_alu = 33'h0_0000_0080; in_rd = 5'd17;
        @(posedge clk);
        #1;
        check_output("rstbusy req before", dmem_bus.dmem_req, 32'd1);
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        #1;
        check_output("rstbusy req", dmem_bus.dmem_req, 32'd0);
        check_output("rstbusy addr", dmem_bus.dmem_addr, 32'd0);
        check_output("rstbusy be", dmem_bus.dmem_be, 32'd0);
        check_output("rstbusy wb_valid", wb_valid, 32'd0);
        check_output("rstbusy stall", stall, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h1234_5678;
        #1;
        check_output("late ack stall", stall, 32'd0);
        @(posedge clk);
        #1;
        check_output("late ack wb_valid", wb_valid, 32'd0);
        check_output("late ack req", dmem_bus.dmem_req, 32'd0);
        @(negedge clk);
        dmem_bus.dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        check_output("late ack wb_valid2", wb_valid, 32'd0);
        run_vector("post-reset alu", vectors[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-003 SHALL have: in_valid  in  1  EX/MEM register holds a live instruction.
REQ-004 SHALL have: in_mem_read, in_mem_write, in_reg_write  in  1 each  decoded control from EX/MEM.
REQ-005 SHALL have: in_wb_sel  in  1  0 = ALU result, 1 = pc+4; ignored for loads.
REQ-006 SHALL have: in_funct3  in  3  access size/sign; in_pc  in  32; in_alu  in  33 (bits [31:0] are the address/result, bit 32 is ignored); in_dat2  in  32  store data; in_rd  in  5.
REQ-007 SHALL have: stall  out  1  combinational; upstream holds EX/MEM while high.
REQ-008 SHALL have these data-memory ports: dmem_req out 1; dmem_we out 1; dmem_be out 4; dmem_addr out 32 (word-aligned, [1:0]=0); dmem_wdata out 32; dmem_ack in 1; dmem_rdata in 32.
REQ-009 SHALL have: wb_valid, wb_reg_write, mem_exc  out  1 each; wb_rd  out  5; wb_data  out  32 (registered MEM/WB outputs).

Function
REQ-010 SHALL implement FSM states IDLE and BUSY.
REQ-011 IDLE with in_valid=0: no memory access; next edge SHALL load wb_valid=0, wb_reg_write=0, mem_exc=0.
REQ-012 IDLE with in_valid=1 and neither mem op: stall=0; next edge SHALL load wb_valid=1, wb_reg_write=in_reg_write, wb_rd=in_rd, and wb_data=in_alu[31:0] (wb_sel=0) or in_pc+4 mod 2^32 (wb_sel=1).
REQ-013 Legal loads SHALL be funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores SHALL be funct3 000 SB, 001 SH, 010 SW.
REQ-014 An access SHALL be faulting if funct3 is illegal, a halfword has addr[0]=1, or a word has addr[1:0]!=0.
REQ-015 IDLE, valid faulting access: stall=0, no dmem_req; next edge SHALL load wb_valid=1, mem_exc=1, wb_reg_write=0, wb_rd=in_rd, wb_data=in_alu[31:0].
REQ-016 IDLE, valid non-faulting access: stall=1; next edge SHALL set dmem_req=1 and go to BUSY with dmem_addr={addr[31:2],2'b00}, dmem_we=in_mem_write, and in_funct3, addr[1:0], in_rd, in_reg_write latched; wb_valid SHALL load 0.
REQ-017 Store lanes: SB SHALL give be=0001<<addr[1:0] with the byte replicated x4; SH SHALL give be=0011<<addr[1:0] with the half replicated x2; SW SHALL give be=1111 with data as-is. Loads SHALL give be=1111 and we=0.
REQ-018 BUSY: dmem_req and all dmem_* outputs SHALL hold stable until dmem_ack=1; stall=1 while dmem_ack=0.
REQ-019 BUSY with dmem_ack=1: stall=0 in that cycle; next edge SHALL clear dmem_req, return to IDLE and load wb_valid=1, mem_exc=0, wb_rd=latched rd.
REQ-020 On load completion, wb_data SHALL be the lane selected by the latched addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU; wb_reg_write SHALL be the latched reg_write.
REQ-021 On store completion, wb_reg_write SHALL be 0 and wb_data SHALL be 0.
REQ-022 dmem_ack SHALL be ignored in IDLE.
REQ-023 An ack in the same cycle as the request SHALL be legal; the minimum access latency is 2 edges from acceptance to wb_valid.
REQ-024 in_mem_read and in_mem_write both high SHALL be treated as a faulting access.

Reset
REQ-025 rst=0 SHALL immediately force state=IDLE and dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, mem_exc=0; stall SHALL evaluate from IDLE.
REQ-026 Reset during BUSY SHALL abandon the access; a late dmem_ack after release SHALL have no effect and SHALL produce no wb_valid.

Verification
REQ-027 ALU op: valid, wb_sel=0, alu=0x1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x00001234, stall never high.
REQ-028 LB at addr 0x103, rdata=0x80FF_0000, ack one cycle after req -> dmem_addr=0x100, stall high 2 cycles, wb_data=0xFFFFFF80.
REQ-029 SH at addr 0x202, dat2=0xABCD1234 -> dmem_be=1100, dmem_wdata=0x12341234, dmem_we=1, wb_reg_write=0 on completion.
REQ-030 LW at addr 0x001 -> no dmem_req, stall=0, next cycle mem_exc=1, wb_reg_write=0.
REQ-031 LHU at 0x002, ack withheld 5 cycles -> dmem_* stable throughout, rdata=0x8001_0000 gives wb_data=0x00008001.
REQ-032 rst=0 asserted mid-BUSY, then ack pulsed after release -> dmem_req=0 immediately, no wb_valid, state IDLE.
